usxgmii_rx_link_fault_detect: RTL

Receive-side reconciliation-sublayer link fault monitor that sits directly downstream of the USXGMII PHY's 32-bit XGMII receive interface. It watches each valid XGMII column for local/remote fault sequence ordered sets and runs the IEEE 802.3 Clause 46 link-fault state machine (consecutive-sequence counter plus 128-column clear window). It reports link status and TX-side fault-response requests, and forwards the XGMII stream unchanged to the MAC with one cycle of latency.

---
 rtl/usxgmii_rx_link_fault_detect.sv | 103 ++++++++++
 1 files changed

// File: rtl/usxgmii_rx_link_fault_detect.sv
// rtl/usxgmii_rx_link_fault_detect.sv - USXGMII receive link fault monitor with 1-cycle XGMII pass-through
module usxgmii_rx_link_fault_detect #(
    parameter int FAULT_SEQ_THRESH = 4,
    parameter int COL_WINDOW       = 128
) (
    input  logic        xgmii_rx_coreclkin,
    input  logic        rx_digitalreset_n,
    input  logic        xgmii_rx_valid,
    input  logic [3:0]  xgmii_rx_control,
    input  logic [31:0] xgmii_rx_data,
    output logic        mac_rx_valid,
    output logic [3:0]  mac_rx_control,
    output logic [31:0] mac_rx_data,
    output logic [1:0]  link_fault,
    output logic        fault_change,
    output logic        tx_send_rf,
    output logic        tx_send_idle
);

    localparam int              CW      = $clog2(COL_WINDOW + 1);
    localparam logic [3:0]      SEQ_MAX = 4'(FAULT_SEQ_THRESH);
    localparam logic [CW-1:0]   COL_MAX = CW'(COL_WINDOW);

    // Encoding matches link_fault so a detected type can be loaded directly.
    typedef enum logic [1:0] {
        FT_NONE   = 2'b00,
        FT_LOCAL  = 2'b01,
        FT_REMOTE = 2'b10
    } fault_type_e;

    fault_type_e   last_type, last_type_nx, col_type;
    logic [3:0]    seq_cnt, seq_cnt_nx;
    logic [CW-1:0] col_cnt, col_cnt_nx;
    logic [1:0]    link_fault_nx;

    always_comb begin
        col_type = FT_NONE;
        if (xgmii_rx_control == 4'b0001 && xgmii_rx_data[23:0] == 24'h00_009C) begin
            if (xgmii_rx_data[31:24] == 8'h01) begin
                col_type = FT_LOCAL;
            end else if (xgmii_rx_data[31:24] == 8'h02) begin
                col_type = FT_REMOTE;
            end
        end
    end

    always_comb begin
        last_type_nx  = last_type;
        seq_cnt_nx    = seq_cnt;
        col_cnt_nx    = col_cnt;
        link_fault_nx = link_fault;
        if (xgmii_rx_valid) begin
            if (col_type != FT_NONE) begin
                col_cnt_nx = '0;
                if (col_type == last_type) begin
                    seq_cnt_nx = (seq_cnt >= SEQ_MAX) ? SEQ_MAX : seq_cnt + 4'd1;
                end else begin
                    last_type_nx = col_type;
                    seq_cnt_nx   = 4'd1;
                end
                if (seq_cnt_nx == SEQ_MAX) begin
                    link_fault_nx = col_type;
                end
            end else begin
                col_cnt_nx = (col_cnt >= COL_MAX) ? COL_MAX : col_cnt + CW'(1);
                if (col_cnt_nx == COL_MAX) begin
                    link_fault_nx = 2'b00;
                    seq_cnt_nx    = 4'd0;
                    last_type_nx  = FT_NONE;
                end
            end
        end
    end

    // TX requests are registered from the next-state value so they are glitch-free
    // yet aligned with link_fault.
    always_ff @(posedge xgmii_rx_coreclkin or negedge rx_digitalreset_n) begin
        if (!rx_digitalreset_n) begin
            mac_rx_valid   <= 1'b0;
            mac_rx_control <= 4'h0;
            mac_rx_data    <= 32'h0;
            last_type      <= FT_NONE;
            seq_cnt        <= 4'd0;
            col_cnt        <= '0;
            link_fault     <= 2'b00;
            fault_change   <= 1'b0;
            tx_send_rf     <= 1'b0;
            tx_send_idle   <= 1'b0;
        end else begin
            mac_rx_valid   <= xgmii_rx_valid;
            mac_rx_control <= xgmii_rx_control;
            mac_rx_data    <= xgmii_rx_data;
            last_type      <= last_type_nx;
            seq_cnt        <= seq_cnt_nx;
            col_cnt        <= col_cnt_nx;
            link_fault     <= link_fault_nx;
            fault_change   <= (link_fault_nx != link_fault);
            tx_send_rf     <= (link_fault_nx == 2'b01);
            tx_send_idle   <= (link_fault_nx == 2'b10);
        end
    end

endmodule
